// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer driving the registered line mux
//
// Ports:
//   clk         bit-rate clock (one period = one bit time)
//   rst         asynchronous active-low reset
//   p_data      parallel byte to transmit, captured when a frame is accepted
//   data_valid  send request, honoured only in IDLE or on the last (stop) cycle
//   par_en      insert parity bit, captured with p_data
//   par_typ     0 = even, 1 = odd parity, captured with p_data
//   mux_sel     line select: 0 start, 1 stop/idle, 2 ser_data, 3 par_bit
//   ser_data    current data bit (shift register bit 0)
//   par_bit     parity of the captured byte, held for the whole frame
//   busy        frame in progress
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'd0;
  localparam logic [1:0] SEL_IDLE   = 2'd1;
  localparam logic [1:0] SEL_DATA   = 2'd2;
  localparam logic [1:0] SEL_PARITY = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [1:0]            mux_sel_q;
  logic                  busy_q;

  // Odd parity is the complement of even parity, so par_typ simply flips the XOR.
  logic par_bit_d;
  assign par_bit_d = (^p_data) ^ par_typ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      mux_sel_q <= SEL_IDLE;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mux_sel_q <= SEL_IDLE;
          busy_q    <= 1'b0;
          if (data_valid) begin
            shift_q   <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= par_bit_d;
            state_q   <= START;
            mux_sel_q <= SEL_START;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          state_q   <= DATA;
          mux_sel_q <= SEL_DATA;
          cnt_q     <= '0;
        end
        DATA: begin
          shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            // Counter parks at the last index rather than wrapping.
            if (par_en_q) begin
              state_q   <= PARITY;
              mux_sel_q <= SEL_PARITY;
            end else begin
              state_q   <= STOP;
              mux_sel_q <= SEL_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          state_q   <= STOP;
          mux_sel_q <= SEL_IDLE;
        end
        STOP: begin
          // A request on the stop cycle chains the next frame with no idle gap.
          if (data_valid) begin
            shift_q   <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= par_bit_d;
            state_q   <= START;
            mux_sel_q <= SEL_START;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= IDLE;
            mux_sel_q <= SEL_IDLE;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mux_sel_q <= SEL_IDLE;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mux_sel  = mux_sel_q;
  assign ser_data = shift_q[0];
  assign par_bit  = par_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle line behaviour: each accepted frame is expanded into a
  // list of bit-times (start, data bits LSB first, optional parity, stop).
  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       is_data;
    logic       sd;
    logic       pb;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{sel: 2'd1, busy: 1'b0, is_data: 1'b0, sd: 1'b0, pb: 1'b0};

  initial begin
    logic pbm;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        cur = '{sel: 2'd1, busy: 1'b0, is_data: 1'b0, sd: 1'b0, pb: 1'b0};
      end else begin
        // A new frame is accepted only when nothing of the current frame remains queued.
        if (data_valid && q.size() == 0) begin
          pbm = 1'b0;
          for (int i = 0; i < W; i++) pbm = pbm ^ p_data[i];
          if (par_typ) pbm = ~pbm;
          q.push_back('{sel: 2'd0, busy: 1'b1, is_data: 1'b0, sd: 1'b0, pb: pbm});
          for (int i = 0; i < W; i++)
            q.push_back('{sel: 2'd2, busy: 1'b1, is_data: 1'b1, sd: p_data[i], pb: pbm});
          if (par_en)
            q.push_back('{sel: 2'd3, busy: 1'b1, is_data: 1'b0, sd: 1'b0, pb: pbm});
          q.push_back('{sel: 2'd1, busy: 1'b1, is_data: 1'b0, sd: 1'b0, pb: pbm});
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{sel: 2'd1, busy: 1'b0, is_data: 1'b0, sd: 1'b0, pb: 1'b0};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("model mux_sel", 32'(mux_sel), 32'(cur.sel));
        check("model busy", 32'(busy), 32'(cur.busy));
        if (cur.is_data) check("model ser_data", 32'(ser_data), 32'(cur.sd));
        if (cur.busy) check("model par_bit", 32'(par_bit), 32'(cur.pb));
      end
    end
  end

  // Sends one byte with a one-cycle request and observes 16 cycles starting with
  // the first frame cycle. A second request can be injected at observation cycle inj_c.
  task automatic run_frame(input logic [7:0] b, input logic pe, input logic pt,
                           input int inj_c, input logic [7:0] inj_b,
                           output int nbusy, output int npar,
                           output logic [7:0] bits, output logic pb);
    int idx;
    idx = 0;
    @(negedge clk);
    p_data = b; par_en = pe; par_typ = pt; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    nbusy = 0; npar = 0; bits = '0; pb = par_bit;
    for (int c = 0; c < 16; c++) begin
      if (c == inj_c) begin
        data_valid = 1'b1; p_data = inj_b; par_en = ~pe; par_typ = ~pt;
      end else if (c == inj_c + 1) begin
        data_valid = 1'b0;
      end
      if (busy) nbusy++;
      if (mux_sel == 2'd2 && idx < 8) begin
        bits[idx] = ser_data;
        idx++;
      end
      if (mux_sel == 2'd3) npar++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, np, nbb;
    logic [7:0] bits;
    logic pb;

    // Reset held with active-looking inputs
    p_data = 8'hFF; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst mux_sel", 32'(mux_sel), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst ser_data", 32'(ser_data), 32'd0);
      check("rst par_bit", 32'(par_bit), 32'd0);
    end
    data_valid = 1'b0;
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post-rst mux_sel", 32'(mux_sel), 32'd1);
      check("post-rst busy", 32'(busy), 32'd0);
    end

    // A5 even parity
    run_frame(8'hA5, 1'b1, 1'b0, -1, 8'h00, nb, np, bits, pb);
    check("A5 even busy len", 32'(nb), 32'd11);
    check("A5 even parity cycles", 32'(np), 32'd1);
    check("A5 even bits", 32'(bits), 32'hA5);
    check("A5 even par_bit", 32'(pb), 32'd0);

    // A5 odd parity
    run_frame(8'hA5, 1'b1, 1'b1, -1, 8'h00, nb, np, bits, pb);
    check("A5 odd busy len", 32'(nb), 32'd11);
    check("A5 odd par_bit", 32'(pb), 32'd1);

    // A5 without parity
    run_frame(8'hA5, 1'b0, 1'b0, -1, 8'h00, nb, np, bits, pb);
    check("A5 nopar busy len", 32'(nb), 32'd10);
    check("A5 nopar parity cycles", 32'(np), 32'd0);
    check("A5 nopar bits", 32'(bits), 32'hA5);

    // Back-to-back: request held, byte changes mid-frame, second byte taken on stop
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    nbb = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 1) p_data = 8'hFF;
      if (i == 12) data_valid = 1'b0;
      if (busy) nbb++;
      if (i == 11) check("b2b first stop sel", 32'(mux_sel), 32'd1);
      if (i == 12) begin
        check("b2b second start sel", 32'(mux_sel), 32'd0);
        check("b2b second par_bit", 32'(par_bit), 32'd0);
      end
    end
    check("b2b busy continuous", 32'(nbb), 32'd22);
    @(negedge clk);
    check("b2b idle after", 32'(busy), 32'd0);

    // Request during DATA is ignored
    run_frame(8'h0F, 1'b0, 1'b0, 4, 8'h00, nb, np, bits, pb);
    check("0F busy len", 32'(nb), 32'd10);
    check("0F bits", 32'(bits), 32'h0F);

    // Request during START is ignored
    run_frame(8'hC3, 1'b1, 1'b1, 0, 8'h81, nb, np, bits, pb);
    check("C3 busy len", 32'(nb), 32'd11);
    check("C3 bits", 32'(bits), 32'hC3);
    check("C3 odd par_bit", 32'(pb), 32'd1);

    // Request during PARITY is ignored
    run_frame(8'h96, 1'b1, 1'b0, 9, 8'h11, nb, np, bits, pb);
    check("96 busy len", 32'(nb), 32'd11);
    check("96 parity cycles", 32'(np), 32'd1);
    check("96 bits", 32'(bits), 32'h96);

    // Reset during data bit 4
    @(negedge clk);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-abort sel", 32'(mux_sel), 32'd2);
    #1 rst = 1'b0;
    #1;
    check("abort mux_sel", 32'(mux_sel), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort next mux_sel", 32'(mux_sel), 32'd1);
    check("abort next busy", 32'(busy), 32'd0);

    run_frame(8'h5A, 1'b0, 1'b1, -1, 8'h00, nb, np, bits, pb);
    check("5A busy len", 32'(nb), 32'd10);
    check("5A bits", 32'(bits), 32'h5A);
    check("5A odd par_bit", 32'(pb), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
